downcounter_param: RTL and testbench
====================================

// Module: downcounter_param
// PURPOSE
//  Parametrised down counter with one-shot and auto-reload modes, for bit/word/frame timing
//  in the serial transmitter channels. Counts down on qualified ticks (cnt & clk_En).
//  Flags terminal count (co_n, active-low at count==1) and zero. Emits a one-cycle done pulse
//  on expiry. Also generates periodic strobes, without external reload logic.
// PARAMETERS
//  WIDTH      5          counter width in bits (>=2)
//  RESET_VAL  2**WIDTH-1 value of count and reload register after reset (all ones)
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high reset
//  init_value   in   WIDTH  load value, also captured as reload value
//  ldcnt        in   1      load request
//  cnt          in   1      count request
//  clk_En       in   1      tick qualifier; decrement only when cnt & clk_En
//  auto_reload  in   1      1: reload on expiry; 0: one-shot; sampled at each step
//  count        out  WIDTH  current count (registered)
//  co_n         out  1      0 when count==1, else 1 (combinational from count)
//  zero         out  1      1 when count==0 (combinational from count)
//  done         out  1      one-cycle pulse on expiry (registered)
//  busy         out  1      1 while state==RUN
// BEHAVIOUR
//  - Clock and reset: clk is the only clock. reset is synchronous, active-high, and has top priority.
//  - Reset values: count=RESET_VAL, reload_q=RESET_VAL, state=IDLE, done=0, busy=0.
//    co_n and zero follow count.
//  - FSM states: IDLE (after reset), RUN, EXPIRED. busy = (state==RUN).
//  - Priority each cycle: reset > ldcnt > step. step = (state==RUN) & cnt & clk_En.
//  - ldcnt (any state): count<=init_value; reload_q<=init_value; done<=0.
//      Next state is RUN if init_value!=0, else EXPIRED (no done pulse).
//      A step in the same cycle is discarded.
//  - IDLE and EXPIRED: steps ignored; count holds. Both states exit only via ldcnt or reset.
//  - step with count>1: count<=count-1; state stays RUN.
//  - step with count==1, auto_reload=0: count<=0; done<=1; state<=EXPIRED.
//  - step with count==1, auto_reload=1: count<=reload_q; done<=1; state stays RUN.
//      Period = reload_q qualified ticks.
//  - done is high for exactly the cycle in which count shows the post-expiry value.
//    It is 0 in every other cycle, including when a step is absent.
//  - Arithmetic: unsigned WIDTH-bit. count never wraps below 0.
//    A 0 count is reachable only via load or one-shot expiry, and is never decremented.
//  - Outputs co_n and zero: combinational decodes of registered count, with no additional latency.
//  - auto_reload may change at any time. It is evaluated only on a step at count==1.
//  - reset mid-count: the next cycle shows reset values. Any pending done is cleared.
// TESTING
//  T1 reset: load 5, step twice, assert reset 1 cycle.
//      Expect count=31, busy=0, done=0, co_n=1, zero=0.
//      Then cnt=clk_En=1 for 4 cycles -> count stays 31 (IDLE).
//  T2 one-shot: load 3, auto_reload=0, cnt=clk_En=1.
//      Expect count 3,2,1,0; co_n=0 only at count 1; done=1 only with count 0.
//      busy falls with done. Further ticks hold 0, zero=1.
//  T3 auto-reload: load 3, auto_reload=1, clk_En every 2nd cycle.
//      Expect count 3,2,1,3,2,1,...; done one cycle at each reload; busy stays 1.
//  T4 collision: count=5, assert ldcnt with init_value=9 and a step in the same cycle.
//      Expect count=9, done=0; the following step gives 8.
//  T5 zero load: load 0.
//      Expect zero=1, co_n=1, busy=0, state EXPIRED; done never pulses; ticks ignored.
//  T6 WIDTH=8 instance: load 255, auto_reload=1, clk_En=1.
//      Expect done every 255 cycles.
//      cnt=1 with clk_En=0 holds count; reset value 255.

Source files
------------

// File: rtl/downcounter_param.sv
// Parametrised down counter with load, one-shot / auto-reload modes and a
// registered expiry pulse; used for bit, word and frame timing.
module downcounter_param #(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] init_value,
  input  logic             ldcnt,
  input  logic             cnt,
  input  logic             clk_En,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             co_n,
  output logic             zero,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             step_s;

  // Next-state logic: load beats any step taken in the same cycle.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    step_s   = (state_q == RUN) & cnt & clk_En;
    if (ldcnt) begin
      count_d  = init_value;
      reload_d = init_value;
      if (init_value != ZERO) begin
        state_d = RUN;
      end else begin
        state_d = EXPIRED;
      end
    end else begin
      case (state_q)
        IDLE, EXPIRED: begin
          state_d = state_q;
        end
        RUN: begin
          if (!step_s) begin
            count_d = count_q;
          end else if (count_q > ONE) begin
            count_d = count_q - ONE;
          end else if (count_q == ONE) begin
            done_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = ZERO;
              state_d = EXPIRED;
            end
          end else begin
            // A zero count is never decremented.
            count_d = count_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, count, reload value and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= RESET_VAL;
      reload_q <= RESET_VAL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign busy  = (state_q == RUN);
  assign co_n  = (count_q != ONE);
  assign zero  = (count_q == ZERO);

endmodule

// File: tb/tb_downcounter_param.sv
// Scoreboard bench for downcounter_param: a WIDTH=5 and a WIDTH=8 instance
// are driven each cycle; expected outputs are queued and popped after the edge.
module tb_downcounter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] init_a;
  logic       ld_a, cnt_a, en_a, ar_a;
  logic [4:0] count_a;
  logic       co_n_a, zero_a, done_a, busy_a;
  logic [7:0] init_b;
  logic       ld_b, cnt_b, en_b, ar_b;
  logic [7:0] count_b;
  logic       co_n_b, zero_b, done_b, busy_b;

  downcounter_param #(.WIDTH(5)) dut_a (
    .clk(clk), .reset(reset), .init_value(init_a), .ldcnt(ld_a), .cnt(cnt_a),
    .clk_En(en_a), .auto_reload(ar_a), .count(count_a), .co_n(co_n_a),
    .zero(zero_a), .done(done_a), .busy(busy_a)
  );

  downcounter_param #(.WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .init_value(init_b), .ldcnt(ld_b), .cnt(cnt_b),
    .clk_En(en_b), .auto_reload(ar_b), .count(count_b), .co_n(co_n_b),
    .zero(zero_b), .done(done_b), .busy(busy_b)
  );

  typedef struct {
    int inst;
    int count;
    int done;
    int busy;
  } exp_t;

  exp_t  sb_q[$];
  int    n_tests  = 0;
  int    n_failed = 0;
  string cur_test = "init";

  // reference model state, per instance (state: 0 idle, 1 run, 2 expired)
  int m_cnt[2];
  int m_rel[2];
  int m_st[2];
  int m_done[2];
  int m_max[2] = '{31, 255};
  int done_b_seen;
  int last_done_b_cycle;
  int cyc;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_failed++;
      $display("FAIL %s/%s: got %0d expected %0d", cur_test, tag, obs, exp_v);
    end
  endtask

  task automatic model_step(input int i, input bit rst, input bit ld, input int iv,
                            input bit c, input bit e, input bit ar);
    if (rst) begin
      m_cnt[i] = m_max[i]; m_rel[i] = m_max[i]; m_st[i] = 0; m_done[i] = 0;
    end else begin
      m_done[i] = 0;
      if (ld) begin
        m_cnt[i] = iv; m_rel[i] = iv; m_st[i] = (iv != 0) ? 1 : 2;
      end else if (m_st[i] == 1 && c && e) begin
        if (m_cnt[i] > 1) begin
          m_cnt[i] = m_cnt[i] - 1;
        end else if (m_cnt[i] == 1) begin
          m_done[i] = 1;
          if (ar) m_cnt[i] = m_rel[i];
          else begin m_cnt[i] = 0; m_st[i] = 2; end
        end
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_step(0, reset, ld_a, int'(init_a), cnt_a, en_a, ar_a);
    model_step(1, reset, ld_b, int'(init_b), cnt_b, en_b, ar_b);
    for (int i = 0; i < 2; i++) begin
      e.inst = i; e.count = m_cnt[i]; e.done = m_done[i]; e.busy = (m_st[i] == 1) ? 1 : 0;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.inst == 0) begin
        check_eq("a_count", int'(count_a), e.count);
        check_eq("a_done",  int'(done_a),  e.done);
        check_eq("a_busy",  int'(busy_a),  e.busy);
        check_eq("a_co_n",  int'(co_n_a),  (e.count != 1) ? 1 : 0);
        check_eq("a_zero",  int'(zero_a),  (e.count == 0) ? 1 : 0);
      end else begin
        check_eq("b_count", int'(count_b), e.count);
        check_eq("b_done",  int'(done_b),  e.done);
        check_eq("b_busy",  int'(busy_b),  e.busy);
        check_eq("b_co_n",  int'(co_n_b),  (e.count != 1) ? 1 : 0);
        check_eq("b_zero",  int'(zero_b),  (e.count == 0) ? 1 : 0);
        if (done_b === 1'b1) begin
          if (done_b_seen > 0) check_eq("b_period", cyc - last_done_b_cycle, 255);
          done_b_seen++;
          last_done_b_cycle = cyc;
        end
      end
    end
  endtask

  task automatic load_a(input int v, input bit ar);
    ld_a = 1'b1; init_a = 5'(v); ar_a = ar;
    cycle();
    ld_a = 1'b0;
  endtask

  initial begin
    cyc = 0; done_b_seen = 0; last_done_b_cycle = 0;
    reset = 1'b1;
    init_a = 5'd0; ld_a = 1'b0; cnt_a = 1'b0; en_a = 1'b0; ar_a = 1'b0;
    init_b = 8'd0; ld_b = 1'b0; cnt_b = 1'b0; en_b = 1'b0; ar_b = 1'b0;
    cycle();
    reset = 1'b0;
    check_eq("b_reset_count", int'(count_b), 255);

    // T1: reset mid-count, then IDLE ignores ticks
    cur_test = "t1";
    load_a(5, 1'b0);
    cnt_a = 1'b1; en_a = 1'b1;
    repeat (2) cycle();
    check_eq("pre_reset_count", int'(count_a), 3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("reset_count", int'(count_a), 31);
    check_eq("reset_busy", int'(busy_a), 0);
    repeat (4) cycle();
    check_eq("idle_hold", int'(count_a), 31);

    // T2: one-shot 3,2,1,0 then hold
    cur_test = "t2";
    cnt_a = 1'b0;
    load_a(3, 1'b0);
    check_eq("load_count", int'(count_a), 3);
    cnt_a = 1'b1; en_a = 1'b1;
    cycle(); cycle();
    check_eq("co_n_at_1", int'(co_n_a), 0);
    cycle();
    check_eq("done_at_0", int'(done_a), 1);
    check_eq("busy_fall", int'(busy_a), 0);
    repeat (3) cycle();
    check_eq("hold_zero", int'(zero_a), 1);
    check_eq("done_gone", int'(done_a), 0);

    // T3: auto-reload, tick every second cycle
    cur_test = "t3";
    load_a(3, 1'b1);
    cnt_a = 1'b1;
    for (int k = 0; k < 16; k++) begin
      en_a = k[0];
      cycle();
    end
    check_eq("busy_stays", int'(busy_a), 1);

    // T4: load collides with a step
    cur_test = "t4";
    en_a = 1'b1; cnt_a = 1'b0;
    load_a(6, 1'b0);
    cnt_a = 1'b1;
    cycle();
    check_eq("count5", int'(count_a), 5);
    ld_a = 1'b1; init_a = 5'd9;
    cycle();
    ld_a = 1'b0;
    check_eq("collide_count", int'(count_a), 9);
    check_eq("collide_done", int'(done_a), 0);
    cycle();
    check_eq("after_collide", int'(count_a), 8);

    // T5: zero load goes straight to EXPIRED
    cur_test = "t5";
    load_a(0, 1'b1);
    repeat (4) cycle();
    check_eq("zero_flag", int'(zero_a), 1);
    check_eq("zero_co_n", int'(co_n_a), 1);
    check_eq("zero_busy", int'(busy_a), 0);

    // random mix on the narrow instance
    cur_test = "rand";
    for (int k = 0; k < 80; k++) begin
      ld_a = ($urandom_range(0, 9) == 0);
      init_a = 5'($urandom_range(0, 6));
      cnt_a = 1'($urandom_range(0, 1));
      en_a = ($urandom_range(0, 3) != 0);
      ar_a = 1'($urandom_range(0, 1));
      cycle();
    end
    ld_a = 1'b0; cnt_a = 1'b0;

    // T6: WIDTH=8 reload of 255, done every 255 ticks
    cur_test = "t6";
    ld_b = 1'b1; init_b = 8'd255; ar_b = 1'b1;
    cycle();
    ld_b = 1'b0;
    cnt_b = 1'b1; en_b = 1'b0;
    repeat (3) cycle();
    check_eq("b_hold_no_en", int'(count_b), 255);
    en_b = 1'b1;
    repeat (520) cycle();
    check_eq("b_done_pulses", done_b_seen, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
